cpu_div_issue: RTL and testbench

- Pipeline-side counterpart of the iterative divider.
- Sits in p3 and converts signed/unsigned DIV/MOD instructions into the divider's magnitude-plus-sign start request, stalling p3 while the divider is occupied.
- Captures the divider's single-cycle result, scoreboards the pending destination register for decode hazards, and arbitrates the result into a free register-file writeback slot.

---
 rtl/cpu_div_issue_if.sv | 50 +++++
 rtl/cpu_div_issue.sv | 107 ++++++++++
 tb/tb_cpu_div_issue.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_div_issue_if.sv
// Bundle of the p3 issue, divider handshake, decode hazard and writeback signals
// shared between the pipeline and the divide issue block.
interface cpu_div_issue_if #(
   parameter int WIDTH = 32,
   parameter int REGW  = 5
);
   logic             p3_valid;
   logic             p3_is_div;
   logic [1:0]       p3_op;
   logic [WIDTH-1:0] p3_src_a;
   logic [WIDTH-1:0] p3_src_b;
   logic [REGW-1:0]  p3_dest;
   logic             p3_stall;
   logic             p3_div_start;
   logic [WIDTH-1:0] p3_numerator;
   logic [WIDTH-1:0] p3_denominator;
   logic [REGW-1:0]  p3_latent_dest;
   logic             p3_div_sign;
   logic             p3_div_mod;
   logic             div_ready;
   logic             div_valid;
   logic [WIDTH-1:0] div_result;
   logic [REGW-1:0]  div_dest_reg;
   logic [REGW-1:0]  rd_reg_a;
   logic [REGW-1:0]  rd_reg_b;
   logic             hazard;
   logic             wb_slot_free;
   logic             wb_en;
   logic [REGW-1:0]  wb_reg;
   logic [WIDTH-1:0] wb_data;
   logic             busy;

   modport master (
      output p3_valid, p3_is_div, p3_op, p3_src_a, p3_src_b, p3_dest,
      output div_ready, div_valid, div_result, div_dest_reg,
      output rd_reg_a, rd_reg_b, wb_slot_free,
      input  p3_stall, p3_div_start, p3_numerator, p3_denominator,
      input  p3_latent_dest, p3_div_sign, p3_div_mod,
      input  hazard, wb_en, wb_reg, wb_data, busy
   );

   modport slave (
      input  p3_valid, p3_is_div, p3_op, p3_src_a, p3_src_b, p3_dest,
      input  div_ready, div_valid, div_result, div_dest_reg,
      input  rd_reg_a, rd_reg_b, wb_slot_free,
      output p3_stall, p3_div_start, p3_numerator, p3_denominator,
      output p3_latent_dest, p3_div_sign, p3_div_mod,
      output hazard, wb_en, wb_reg, wb_data, busy
   );
endinterface

// File: rtl/cpu_div_issue.sv
// Issues DIV/MOD from p3 to the iterative divider as magnitude plus sign, tracks the
// pending destination for decode hazards and retires the result into a free writeback slot.
module cpu_div_issue #(
   parameter int WIDTH = 32,
   parameter int REGW  = 5
) (
   input logic           clock,
   input logic           reset,
   cpu_div_issue_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      HOLD = 2'b10
   } state_t;

   state_t           state_r;
   logic [REGW-1:0]  pending_dest_r;
   logic [REGW-1:0]  hold_reg_r;
   logic [WIDTH-1:0] hold_data_r;

   logic             div_req_s;
   logic             stall_s;
   logic             start_s;
   logic             sign_s;
   logic             busy_s;
   logic             hazard_s;
   logic             wb_en_s;
   logic [WIDTH-1:0] num_s;
   logic [WIDTH-1:0] den_s;

   // Two's-complement magnitude; the most negative value maps onto itself, which is
   // the correct unsigned magnitude.
   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic is_signed);
      if (is_signed && v[WIDTH-1]) begin
         magnitude = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
      end else begin
         magnitude = v;
      end
   endfunction

   // Issue decision, operand conditioning, hazard and writeback enable.
   always_comb begin
      div_req_s = reset & bus.p3_valid & bus.p3_is_div;
      stall_s   = div_req_s & ((state_r != IDLE) | ~bus.div_ready);
      start_s   = div_req_s & ~stall_s;
      num_s     = magnitude(bus.p3_src_a, bus.p3_op[1]);
      den_s     = magnitude(bus.p3_src_b, bus.p3_op[1]);
      if (!bus.p3_op[1]) begin
         sign_s = 1'b0;
      end else if (bus.p3_op[0]) begin
         sign_s = bus.p3_src_a[WIDTH-1];
      end else begin
         sign_s = bus.p3_src_a[WIDTH-1] ^ bus.p3_src_b[WIDTH-1];
      end
      busy_s   = reset & (state_r != IDLE);
      hazard_s = busy_s & (pending_dest_r != {REGW{1'b0}}) &
                 ((bus.rd_reg_a == pending_dest_r) | (bus.rd_reg_b == pending_dest_r));
      wb_en_s  = reset & (state_r == HOLD) & bus.wb_slot_free & (hold_reg_r != {REGW{1'b0}});
   end

   // Outstanding-divide state machine with result capture.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_r        <= IDLE;
         pending_dest_r <= {REGW{1'b0}};
         hold_reg_r     <= {REGW{1'b0}};
         hold_data_r    <= {WIDTH{1'b0}};
      end else begin
         case (state_r)
            IDLE: begin
               if (start_s) begin
                  state_r        <= BUSY;
                  pending_dest_r <= bus.p3_dest;
               end
            end
            BUSY: begin
               if (bus.div_valid) begin
                  state_r     <= HOLD;
                  hold_data_r <= bus.div_result;
                  hold_reg_r  <= bus.div_dest_reg;
               end
            end
            HOLD: begin
               // r0 results are dropped without waiting for a slot
               if (wb_en_s || (hold_reg_r == {REGW{1'b0}})) begin
                  state_r <= IDLE;
               end
            end
            default: state_r <= IDLE;
         endcase
      end
   end

   assign bus.p3_stall       = stall_s;
   assign bus.p3_div_start   = start_s;
   assign bus.p3_numerator   = num_s;
   assign bus.p3_denominator = den_s;
   assign bus.p3_latent_dest = bus.p3_dest;
   assign bus.p3_div_sign    = sign_s;
   assign bus.p3_div_mod     = bus.p3_op[0];
   assign bus.hazard         = hazard_s;
   assign bus.wb_en          = wb_en_s;
   assign bus.wb_reg         = hold_reg_r;
   assign bus.wb_data        = hold_data_r;
   assign bus.busy           = busy_s;
endmodule

// File: tb/tb_cpu_div_issue.sv
// Scoreboard bench for cpu_div_issue: a behavioural divider answers start requests,
// expected writebacks come from 64-bit reference arithmetic on the original operands.
module tb_cpu_div_issue;
   bit   clock = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   cpu_div_issue_if #(.WIDTH(32), .REGW(5)) bus ();

   cpu_div_issue #(.WIDTH(32), .REGW(5)) dut (
      .clock (clock),
      .reset (rst),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   logic [36:0] sb_q[$];
   int          issued_nz = 0;
   int          wb_count = 0;
   int          flushed = 0;
   logic [4:0]  last_dest = 5'd0;
   bit          idle_known = 1'b1;
   bit          arrived = 1'b0;
   bit          inject_stray = 1'b0;
   bit          long_lat = 1'b0;
   int          slot_mode = 0;
   bit          dv_busy = 1'b0;
   int          dv_cnt = 0;
   logic [31:0] dv_res = 32'd0;
   logic [4:0]  dv_dest = 5'd0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural divider: latches a start seen before the edge.
   task automatic model_capture();
      logic [31:0] q, rm, v;
      if (rst && bus.p3_div_start) begin
         q  = (bus.p3_denominator == 32'd0) ? 32'hFFFF_FFFF : bus.p3_numerator / bus.p3_denominator;
         rm = (bus.p3_denominator == 32'd0) ? bus.p3_numerator : bus.p3_numerator % bus.p3_denominator;
         v  = bus.p3_div_mod ? rm : q;
         dv_res  = bus.p3_div_sign ? (32'd0 - v) : v;
         dv_dest = bus.p3_latent_dest;
         dv_busy = 1'b1;
         dv_cnt  = long_lat ? 20 : $urandom_range(0, 4);
      end
   endtask

   task automatic pos_phase();
      @(posedge clock);
      #1;
      bus.div_valid = 1'b0;
      if (!rst) begin
         dv_busy = 1'b0;
      end else if (inject_stray) begin
         bus.div_valid    = 1'b1;
         bus.div_result   = 32'hDEAD_BEEF;
         bus.div_dest_reg = 5'd7;
         inject_stray     = 1'b0;
      end else if (dv_busy) begin
         if (dv_cnt == 0) begin
            bus.div_valid    = 1'b1;
            bus.div_result   = dv_res;
            bus.div_dest_reg = dv_dest;
            dv_busy          = 1'b0;
         end else begin
            dv_cnt--;
         end
      end
      bus.div_ready = !dv_busy && ($urandom_range(0, 3) != 0);
      case (slot_mode)
         1: bus.wb_slot_free = 1'b0;
         2: bus.wb_slot_free = 1'b1;
         default: bus.wb_slot_free = ($urandom_range(0, 2) != 0);
      endcase
      bus.rd_reg_a = ($urandom_range(0, 1) == 1) ? last_dest : 5'($urandom_range(0, 31));
      bus.rd_reg_b = ($urandom_range(0, 1) == 1) ? last_dest : 5'($urandom_range(0, 31));
   endtask

   task automatic tick();
      @(negedge clock);
      model_capture();
      pos_phase();
   endtask

   task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] dest);
      longint sa, sb, r, ma, mb;
      bit es, got, outst;
      sa = op[1] ? longint'($signed(a)) : longint'({32'd0, a});
      sb = op[1] ? longint'($signed(b)) : longint'({32'd0, b});
      r  = op[0] ? (sa % sb) : (sa / sb);
      ma = (sa < 0) ? -sa : sa;
      mb = (sb < 0) ? -sb : sb;
      es = op[1] && (op[0] ? (sa < 0) : ((sa < 0) != (sb < 0)));
      bus.p3_valid  = 1'b1;
      bus.p3_is_div = 1'b1;
      bus.p3_op     = op;
      bus.p3_src_a  = a;
      bus.p3_src_b  = b;
      bus.p3_dest   = dest;
      got = 1'b0;
      for (int n = 0; n < 100 && !got; n++) begin
         @(negedge clock);
         outst = (issued_nz != wb_count + flushed);
         if (outst) chk("stall_outstanding", bus.p3_stall, 1'b1);
         else if (idle_known) chk("stall_idle", bus.p3_stall, !bus.div_ready);
         if (!bus.p3_stall) begin
            chk("start", bus.p3_div_start, 1'b1);
            chk("numerator", bus.p3_numerator, ma[31:0]);
            chk("denominator", bus.p3_denominator, mb[31:0]);
            chk("sign", bus.p3_div_sign, es);
            chk("mod", bus.p3_div_mod, op[0]);
            chk("latent_dest", bus.p3_latent_dest, dest);
            if (dest != 5'd0) sb_q.push_back({dest, r[31:0]});
            got = 1'b1;
         end else begin
            chk("start_held", bus.p3_div_start, 1'b0);
         end
         model_capture();
         pos_phase();
      end
      bus.p3_valid = 1'b0;
      if (got) begin
         if (dest != 5'd0) issued_nz++;
         last_dest  = dest;
         idle_known = (dest != 5'd0);
      end else begin
         chk("issue_timeout", 64'd0, 64'd1);
      end
   endtask

   task automatic wait_retire();
      int n = 0;
      while (issued_nz != wb_count + flushed && n < 100) begin
         tick();
         n++;
      end
      if (n >= 100) chk("retire_timeout", 64'd0, 64'd1);
   endtask

   // Monitor: checks writeback against the scoreboard and hazard against outstanding work.
   always begin
      bit outst, exp_wb, exp_haz;
      logic [36:0] e;
      @(negedge clock);
      #2;
      if (!rst) begin
         chk("reset_outputs", {bus.p3_div_start, bus.p3_stall, bus.hazard, bus.wb_en, bus.busy}, 64'd0);
         arrived = 1'b0;
      end else begin
         outst   = (issued_nz != wb_count + flushed);
         exp_haz = outst && (bus.rd_reg_a == last_dest || bus.rd_reg_b == last_dest);
         chk("hazard", bus.hazard, exp_haz);
         exp_wb = arrived && bus.wb_slot_free;
         chk("wb_en", bus.wb_en, exp_wb);
         if (bus.wb_en) begin
            if (sb_q.size() == 0) begin
               chk("wb_unexpected", 64'd1, 64'd0);
            end else begin
               e = sb_q.pop_front();
               chk("wb_reg", bus.wb_reg, e[36:32]);
               chk("wb_data", bus.wb_data, e[31:0]);
            end
            wb_count++;
         end
         if (exp_wb) arrived = 1'b0;
         else if (bus.div_valid && outst && !arrived) arrived = 1'b1;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a, b;
      int n;
      rst = 1'b0;
      bus.p3_valid = 1'b0;  bus.p3_is_div = 1'b0;  bus.p3_op = 2'd0;
      bus.p3_src_a = 32'd0; bus.p3_src_b = 32'd0;  bus.p3_dest = 5'd0;
      bus.div_ready = 1'b1; bus.div_valid = 1'b0;  bus.div_result = 32'd0;
      bus.div_dest_reg = 5'd0; bus.rd_reg_a = 5'd0; bus.rd_reg_b = 5'd0;
      bus.wb_slot_free = 1'b0;
      repeat (3) tick();
      rst = 1'b1;
      @(negedge clock);
      chk("busy_after_reset", bus.busy, 1'b0);
      model_capture();
      pos_phase();

      slot_mode = 2;
      issue(2'b10, 32'hFFFF_FFF9, 32'd2, 5'd5);
      wait_retire();
      issue(2'b11, 32'hFFFF_FFF9, 32'd2, 5'd6);
      issue(2'b01, 32'hFFFF_FFF9, 32'd2, 5'd7);
      issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8);
      issue(2'b00, 32'd1000, 32'd7, 5'd9);
      issue(2'b10, 32'd77, 32'hFFFF_FFF6, 5'd3);
      wait_retire();

      // Result waits four cycles for a free writeback slot.
      slot_mode = 1;
      issue(2'b00, 32'd100, 32'd7, 5'd10);
      n = 0;
      while (!arrived && n < 50) begin
         tick();
         n++;
      end
      if (n >= 50) chk("arrive_timeout", 64'd0, 64'd1);
      repeat (4) tick();
      slot_mode = 2;
      bus.wb_slot_free = 1'b1;
      tick();
      @(negedge clock);
      chk("busy_after_wb", bus.busy, 1'b0);
      model_capture();
      pos_phase();

      slot_mode = 0;
      issue(2'b10, 32'd100, 32'd3, 5'd0);
      repeat (8) tick();
      @(negedge clock);
      chk("busy_after_r0", bus.busy, 1'b0);
      model_capture();
      pos_phase();

      // Reset in the middle of a long divide, then a stray result.
      long_lat = 1'b1;
      issue(2'b00, 32'd1000, 32'd10, 5'd12);
      tick();
      @(negedge clock);
      chk("busy_running", bus.busy, 1'b1);
      model_capture();
      pos_phase();
      rst = 1'b0;
      flushed++;
      sb_q.delete();
      idle_known = 1'b1;
      long_lat = 1'b0;
      tick();
      rst = 1'b1;
      bus.rd_reg_a = 5'd12;
      @(negedge clock);
      chk("busy_post_reset", bus.busy, 1'b0);
      chk("hazard_post_reset", bus.hazard, 1'b0);
      model_capture();
      pos_phase();
      inject_stray = 1'b1;
      repeat (4) tick();
      @(negedge clock);
      chk("busy_after_stray", bus.busy, 1'b0);
      model_capture();
      pos_phase();

      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 5))
            0: a = 32'h8000_0000;
            1: a = 32'hFFFF_FFFF;
            default: a = $urandom;
         endcase
         case ($urandom_range(0, 4))
            0: b = 32'hFFFF_FFFF;
            1: b = 32'($urandom_range(1, 20));
            default: b = $urandom;
         endcase
         if (b == 32'd0) b = 32'd1;
         issue(2'($urandom_range(0, 3)), a, b, 5'($urandom_range(0, 31)));
         repeat ($urandom_range(0, 2)) tick();
      end
      wait_retire();
      repeat (6) tick();
      chk("scoreboard_empty", sb_q.size(), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
